// File: rtl/mem_burst_reader_pkg.sv
// mem_pkg: shared definitions for the burst reader slice.
//   ADDR_W / DATA_W / RAM_DEPTH : default geometry of the external block RAM
//   FIFO_DEPTH                  : number of slots in the output skid buffer
//   state_t                     : burst reader FSM states
//   credit_ok()                 : decides whether another RAM read may be launched
package mem_pkg;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 16;
  localparam int RAM_DEPTH  = 2048;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // A read may be launched only if every word already owed to the output
  // (buffered words, minus the one leaving this cycle, plus the read whose
  // data is on the RAM output now) still leaves a free FIFO slot for it.
  function automatic logic credit_ok(input logic [1:0] occupancy,
                                     input logic       xfer,
                                     input logic       inflight);
    logic [2:0] need;
    need = {1'b0, occupancy} + {2'b00, inflight} + 3'd1 - {2'b00, xfer};
    return need <= 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/mem_burst_reader_if.sv
// mem_burst_reader_if: bundles the command, RAM port A and output stream
// signals of the burst reader.
//   command : start, start_addr, burst_len  -> reader ; busy, done <- reader
//   RAM A   : mem_addra, mem_wea, mem_dina  <- reader ; mem_douta -> reader
//   stream  : rd_data, rd_valid, rd_last    <- reader ; rd_ready  -> reader
// modport master is the reader's view, modport slave the environment's view.
interface mem_burst_reader_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   burst_len;
  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] mem_addra;
  logic              mem_wea;
  logic [DATA_W-1:0] mem_dina;
  logic [DATA_W-1:0] mem_douta;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;

  modport master (
    input  start, start_addr, burst_len, mem_douta, rd_ready,
    output busy, done, mem_addra, mem_wea, mem_dina, rd_data, rd_valid, rd_last
  );

  modport slave (
    output start, start_addr, burst_len, mem_douta, rd_ready,
    input  busy, done, mem_addra, mem_wea, mem_dina, rd_data, rd_valid, rd_last
  );

endinterface

// File: rtl/blockmem16kx1.sv
// blockmem16kx1: block RAM model with one read-first port A and a write-only
// port B, both on clka. Read data appears one clock after the address.
//   clka                : clock
//   addra/wea/dina/douta: port A (read/write)
//   addrb/web/dinb      : port B (write only, used for preloading)
module blockmem16kx1 #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic              clka,
  input  logic [ADDR_W-1:0] addra,
  input  logic              wea,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  input  logic [ADDR_W-1:0] addrb,
  input  logic              web,
  input  logic [DATA_W-1:0] dinb
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Both write ports and the registered read live in one process so the
  // array has a single driver.
  always_ff @(posedge clka) begin
    if (wea) begin
      mem[addra] <= dina;
    end
    if (web) begin
      mem[addrb] <= dinb;
    end
    douta <= mem[addra];
  end

endmodule

// File: rtl/mem_burst_reader_skid_fifo2.sv
// skid_fifo2: two-entry FIFO feeding a valid/ready stream.
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : write side (caller guarantees a free slot)
//   out_ready           : consumer accepts the head word
//   out_valid, out_data : head word, taken straight from a register
//   count               : current occupancy 0..2
module skid_fifo2 #(
  parameter int WIDTH = mem_pkg::DATA_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             pop;

  assign pop       = (count_q != 2'd0) && out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

  // Entries are cleared as they drain, so an empty FIFO presents all zeros
  // (in particular a zero "last" flag) and the tail is zero whenever only
  // the head is occupied.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q  <= push_data;
            count_q <= 2'd1;
          end else if (count_q == 2'd1) begin
            tail_q  <= push_data;
            count_q <= 2'd2;
          end
        end
        2'b01: begin
          head_q  <= tail_q;
          tail_q  <= '0;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: reads burst_len consecutive words from an external block
// RAM starting at start_addr and streams them out on a valid/ready channel,
// flagging the final word with rd_last and pulsing done afterwards.
//   clka  : clock
//   reset : synchronous active-high reset
//   bus   : mem_burst_reader_if.master
//           command start/start_addr/burst_len in, busy/done out
//           RAM port A mem_addra/mem_wea/mem_dina out, mem_douta in
//           stream rd_data/rd_valid/rd_last out, rd_ready in
module mem_burst_reader #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
) (
  input  logic                clka,
  input  logic                reset,
  mem_burst_reader_if.master  bus
);

  import mem_pkg::*;

  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W:0]   issue_left;
  logic              inflight;
  logic              inflight_last;
  logic              busy_q;
  logic              done_q;

  logic              xfer;
  logic              issue;
  logic              accept;
  logic              fifo_valid;
  logic [DATA_W:0]   fifo_data;
  logic [1:0]        fifo_count;

  assign xfer   = fifo_valid && bus.rd_ready;
  assign issue  = (state == ISSUE) && credit_ok(fifo_count, xfer, inflight);
  assign accept = bus.start && !busy_q && (state == IDLE);

  // mem_addra always shows the next address to read. The RAM reads it every
  // cycle regardless; a read only counts when "issue" is high, in which case
  // the address advances and the returning word is marked in flight so it is
  // captured into the FIFO on the following edge. Untracked reads are simply
  // ignored. busy covers the done cycle, which is what makes a start that
  // coincides with done get dropped.
  always_ff @(posedge clka) begin
    if (reset) begin
      state         <= IDLE;
      mem_addr_q    <= '0;
      issue_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (issue_left == LEN_ONE);
      if (done_q) begin
        busy_q <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            if (bus.burst_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state      <= ISSUE;
              mem_addr_q <= bus.start_addr;
              issue_left <= bus.burst_len;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            mem_addr_q <= mem_addr_q + ADDR_ONE;
            issue_left <= issue_left - LEN_ONE;
            if (issue_left == LEN_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (xfer && fifo_data[DATA_W]) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The last flag travels alongside each word through the buffer, so the
  // final word keeps its marker no matter how long it is stalled.
  skid_fifo2 #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clk       (clka),
    .reset     (reset),
    .push      (inflight),
    .push_data ({inflight_last, bus.mem_douta}),
    .out_ready (bus.rd_ready),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .count     (fifo_count)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_addra = mem_addr_q;
  assign bus.mem_wea   = 1'b0;
  assign bus.mem_dina  = '0;
  assign bus.rd_data   = fifo_data[DATA_W-1:0];
  assign bus.rd_valid  = fifo_valid;
  assign bus.rd_last   = fifo_data[DATA_W];

endmodule
